neuron_mac_lanes: RTL and testbench

Parametrised successor to the single-lane ELM neuron. It consumes LANES input samples per beat against LANES weights stored in local RAM, and accumulates in a widened, saturating accumulator. It then adds bias and applies a runtime-selectable activation (identity / ReLU / hard-sigmoid). The block sits in a layer array behind the AXI config path and emits one DATA_W result per inference through a valid/ready handshake with backpressure.

---
 rtl/neuron_pkg.sv | 43 ++++
 rtl/neuron_lane_ram.sv | 25 ++
 rtl/neuron_mac_lanes.sv | 188 ++++++++++++++++++
 tb/tb_neuron_mac_lanes.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types, sizing helpers and saturation for neuron blocks
package neuron_pkg;

   typedef enum logic [1:0] {
      ACT_IDENT = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_HSIG  = 2'd2,
      ACT_RSVD  = 2'd3
   } act_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_BIAS,
      ST_ACT,
      ST_OUT
   } state_t;

   // Widened accumulator: full product width, growth over all weights, plus a guard bit.
   function automatic int calc_acc_w(input int data_w, input int num_weight);
      return 2 * data_w + $clog2(num_weight) + 1;
   endfunction

   function automatic int calc_depth(input int num_weight, input int lanes);
      return num_weight / lanes;
   endfunction

   // Clamp a signed value to the range of a w-bit two's complement number.
   function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/neuron_lane_ram.sv
// rtl/neuron_lane_ram.sv - simple dual-port weight RAM with registered read
module neuron_lane_ram #(
   parameter int DEPTH  = 32,
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and one-cycle registered read port; contents are never cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/neuron_mac_lanes.sv
// rtl/neuron_mac_lanes.sv - multi-lane MAC neuron with bias, activation and output handshake
module neuron_mac_lanes
   import neuron_pkg::*;
#(
   parameter int LAYER_NO   = 1,
   parameter int NEURON_NO  = 0,
   parameter int DATA_W     = 16,
   parameter int FRAC_W     = 8,
   parameter int NUM_WEIGHT = 128,
   parameter int LANES      = 4,
   parameter int CFG_W      = 33
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CFG_W-1:0]          cfg_layer_num,
   input  logic [CFG_W-1:0]          cfg_neuron_num,
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic [LANES*DATA_W-1:0]   w_data,
   input  logic                      b_valid,
   input  logic [DATA_W-1:0]         b_data,
   input  logic [1:0]                act_mode,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data
);

   localparam int DEPTH  = calc_depth(NUM_WEIGHT, LANES);
   localparam int ACC_W  = calc_acc_w(DATA_W, NUM_WEIGHT);
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;

   state_t                    state, state_nxt;
   act_mode_t                 mode_q;
   logic [AW-1:0]             w_addr;
   logic [AW-1:0]             beat_cnt;
   logic signed [DATA_W-1:0]  bias;
   logic                      cfg_hit, w_fire, in_fire, last_beat;

   logic [LANES*DATA_W-1:0]   ram_rdata;
   logic [LANES*DATA_W-1:0]   s1_x;
   logic                      s1_v, s2_v, s3_v;
   logic signed [PROD_W-1:0]  prod [LANES];
   logic signed [SUM_W-1:0]   sum_c, s3_sum;
   logic signed [ACC_W-1:0]   acc, acc_sum;
   logic signed [63:0]        add_in, hs;
   logic signed [DATA_W-1:0]  y_c, act_c;

   assign cfg_hit   = (cfg_layer_num == CFG_W'(LAYER_NO)) && (cfg_neuron_num == CFG_W'(NEURON_NO));
   assign w_fire    = w_valid && w_ready && cfg_hit;
   assign in_fire   = in_valid && in_ready;
   assign last_beat = in_fire && (beat_cnt == AW'(DEPTH - 1));

   neuron_lane_ram #(
      .DEPTH  (DEPTH),
      .WIDTH  (LANES * DATA_W),
      .ADDR_W (AW)
   ) u_ram (
      .clk   (clk),
      .we    (w_fire),
      .waddr (w_addr),
      .wdata (w_data),
      .raddr (beat_cnt),
      .rdata (ram_rdata)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: accept beats, drain the MAC pipeline, then bias, activate and hand off.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (in_fire) state_nxt = last_beat ? ST_DRAIN : ST_ACCUM;
         ST_ACCUM: if (last_beat) state_nxt = ST_DRAIN;
         ST_DRAIN: if (!s1_v && !s2_v && !s3_v) state_nxt = ST_BIAS;
         ST_BIAS:  state_nxt = ST_ACT;
         ST_ACT:   state_nxt = ST_OUT;
         ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Handshake readies derived from state.
   always_comb begin
      in_ready = (state == ST_IDLE) || (state == ST_ACCUM);
      w_ready  = (state == ST_IDLE);
   end

   // Config-side storage: weight write pointer, bias register and latched activation mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_addr <= '0;
      end else if (w_fire) begin
         w_addr <= (w_addr == AW'(DEPTH - 1)) ? '0 : w_addr + AW'(1);
      end
      if (b_valid && cfg_hit) begin
         bias <= b_data;
      end
      if (in_fire && state == ST_IDLE) begin
         mode_q <= act_mode_t'(act_mode);
      end
   end

   // MAC pipeline S1 (input register), S2 (lane products), S3 (lane sum).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s3_v <= 1'b0;
      end else begin
         s1_v <= in_fire;
         s2_v <= s1_v;
         s3_v <= s2_v;
      end
      if (in_fire) begin
         s1_x <= in_data;
      end
      if (s1_v) begin
         for (int i = 0; i < LANES; i++) begin
            prod[i] <= PROD_W'($signed(s1_x[i*DATA_W +: DATA_W]))
                     * PROD_W'($signed(ram_rdata[i*DATA_W +: DATA_W]));
         end
      end
      if (s2_v) begin
         s3_sum <= sum_c;
      end
   end

   // Lane reduction, saturating accumulator add, and output scaling/activation.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_c = sum_c + SUM_W'(prod[i]);
      end
      add_in  = s3_v ? 64'(s3_sum) : (64'(bias) <<< FRAC_W);
      acc_sum = ACC_W'(sat_to_w(64'(acc) + add_in, ACC_W));
      y_c     = DATA_W'(sat_to_w(64'(acc) >>> FRAC_W, DATA_W));
      hs      = (64'(y_c) >>> 2) + (64'sd1 <<< (FRAC_W - 1));
      if (hs < 64'sd0) begin
         hs = 64'sd0;
      end else if (hs > (64'sd1 <<< FRAC_W)) begin
         hs = 64'sd1 <<< FRAC_W;
      end
      case (mode_q)
         ACT_RELU: act_c = (y_c < 0) ? '0 : y_c;
         ACT_HSIG: act_c = DATA_W'(hs);
         default:  act_c = y_c;
      endcase
   end

   // Accumulator, beat counter and registered result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (in_fire) begin
            beat_cnt <= (beat_cnt == AW'(DEPTH - 1)) ? '0 : beat_cnt + AW'(1);
         end
         if (s3_v || state == ST_BIAS) begin
            acc <= acc_sum;
         end
         if (state == ST_ACT) begin
            out_valid <= 1'b1;
            out_data  <= act_c;
         end
         if (state == ST_OUT && out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// tb/tb_neuron_mac_lanes.sv - directed self-checking bench for neuron_mac_lanes
module tb_neuron_mac_lanes;

   localparam int DW    = 16;
   localparam int FW    = 8;
   localparam int NW    = 8;
   localparam int LN    = 4;
   localparam int DEPTH = NW / LN;
   localparam int CW    = 33;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [CW-1:0]    cfg_layer_num, cfg_neuron_num;
   logic             w_valid, w_ready;
   logic [LN*DW-1:0] w_data;
   logic             b_valid;
   logic [DW-1:0]    b_data;
   logic [1:0]       act_mode;
   logic             in_valid, in_ready;
   logic [LN*DW-1:0] in_data;
   logic             out_valid, out_ready;
   logic [DW-1:0]    out_data;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_cyc = 0;
   int mon_beats = 0;
   logic prev_ov = 1'b0;

   logic [LN*DW-1:0] m_ram [DEPTH];
   int               m_waddr;
   logic [DW-1:0]    m_bias;
   logic [DW-1:0]    exp_q [$];

   neuron_mac_lanes #(
      .LAYER_NO   (1),
      .NEURON_NO  (0),
      .DATA_W     (DW),
      .FRAC_W     (FW),
      .NUM_WEIGHT (NW),
      .LANES      (LN),
      .CFG_W      (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_layer_num  (cfg_layer_num),
      .cfg_neuron_num (cfg_neuron_num),
      .w_valid        (w_valid),
      .w_ready        (w_ready),
      .w_data         (w_data),
      .b_valid        (b_valid),
      .b_data         (b_data),
      .act_mode       (act_mode),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic longint s16(input logic [DW-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // Reference: fixed-point dot product over all weights, bias, scale, activation.
   function automatic logic [DW-1:0] model_out(input logic [LN*DW-1:0] x0, input logic [LN*DW-1:0] x1,
                                               input logic [1:0] mode);
      longint acc, beat, y, hi, lo;
      logic [LN*DW-1:0] xs [DEPTH];
      xs[0] = x0;
      xs[1] = x1;
      hi = (longint'(1) <<< 39) - 1;
      lo = -(longint'(1) <<< 39);
      acc = 0;
      for (int b = 0; b < DEPTH; b++) begin
         beat = 0;
         for (int l = 0; l < LN; l++) begin
            beat = beat + s16(m_ram[b][l*DW +: DW]) * s16(xs[b][l*DW +: DW]);
         end
         acc = clamp(acc + beat, lo, hi);
      end
      acc = clamp(acc + s16(m_bias) * 256, lo, hi);
      y = clamp(acc >>> FW, -32768, 32767);
      if (mode == 2'd1 && y < 0) y = 0;
      else if (mode == 2'd2) y = clamp((y >>> 2) + 128, 0, 256);
      return y[DW-1:0];
   endfunction

   // Output monitor: result value, stability, latency and back-pressure behaviour.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_beats = 0;
         prev_ov = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            mon_beats++;
            if (mon_beats == DEPTH) begin
               mon_beats = 0;
               last_cyc = cyc + 1;
            end
         end
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'(0));
         end else if (out_valid) begin
            if (!prev_ov) check("latency", 64'(cyc - last_cyc), 64'(6));
            check("out_data", 64'(out_data), 64'(exp_q[0]));
            check("in_ready_while_out", 64'(in_ready), 64'(0));
            if (out_ready) void'(exp_q.pop_front());
         end
         prev_ov = out_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_w(input logic [LN*DW-1:0] d, input logic [CW-1:0] neuron);
      cfg_layer_num = 33'd1;
      cfg_neuron_num = neuron;
      w_data = d;
      w_valid = 1'b1;
      if (w_ready && neuron == 33'd0) begin
         m_ram[m_waddr] = d;
         m_waddr = (m_waddr + 1) % DEPTH;
      end
      tick();
      w_valid = 1'b0;
      cfg_neuron_num = '0;
   endtask

   task automatic load_b(input logic [DW-1:0] b);
      cfg_layer_num = 33'd1;
      cfg_neuron_num = 33'd0;
      b_data = b;
      b_valid = 1'b1;
      m_bias = b;
      tick();
      b_valid = 1'b0;
   endtask

   task automatic run_inf(input string name, input logic [LN*DW-1:0] x0, input logic [LN*DW-1:0] x1,
                          input logic [1:0] mode, input int gap, input int hold, input logic [DW-1:0] lit);
      logic [DW-1:0] e;
      int guard;
      e = model_out(x0, x1, mode);
      check({"model_", name}, 64'(e), 64'(lit));
      exp_q.push_back(e);
      act_mode = mode;
      for (int b = 0; b < DEPTH; b++) begin
         in_data = (b == 0) ? x0 : x1;
         in_valid = 1'b1;
         guard = 0;
         while (!in_ready && guard < 50) begin
            tick();
            guard++;
         end
         check({"beat_accept_", name}, 64'(in_ready), 64'(1));
         tick();
         in_valid = 1'b0;
         act_mode = (mode == 2'd2) ? 2'd0 : 2'd2;
         repeat (gap) tick();
      end
      guard = 0;
      while (!out_valid && guard < 50) begin
         tick();
         guard++;
      end
      check({"out_valid_", name}, 64'(out_valid), 64'(1));
      check({"lit_", name}, 64'(out_data), 64'(lit));
      if (hold > 0) begin
         repeat (hold) tick();
         check({"held_valid_", name}, 64'(out_valid), 64'(1));
         check({"held_data_", name}, 64'(out_data), 64'(lit));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({"post_valid_", name}, 64'(out_valid), 64'(0));
      check({"post_in_ready_", name}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      cfg_layer_num = '0;
      cfg_neuron_num = '0;
      w_valid = 1'b0;
      w_data = '0;
      b_valid = 1'b0;
      b_data = '0;
      act_mode = 2'd0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      m_waddr = 0;
      m_bias = '0;
      repeat (3) tick();
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_w_ready", 64'(w_ready), 64'(1));
      rst_n = 1'b1;
      tick();

      load_b(16'h0040);
      load_w({4{16'h0100}}, 33'd0);
      load_w({4{16'h0100}}, 33'd0);
      repeat (3) load_w({4{16'h7FFF}}, 33'd5);
      run_inf("identity", {4{16'h0080}}, {4{16'h0080}}, 2'd0, 0, 0, 16'h0440);

      load_b(16'hF800);
      run_inf("relu", {4{16'h0080}}, {4{16'h0080}}, 2'd1, 0, 0, 16'h0000);
      load_b(16'hFC00);
      run_inf("hsig", {4{16'h0080}}, {4{16'h0080}}, 2'd2, 0, 0, 16'h0080);

      load_b(16'h0000);
      load_w({4{16'h7FFF}}, 33'd0);
      load_w({4{16'h7FFF}}, 33'd0);
      run_inf("sat_pos", {4{16'h7FFF}}, {4{16'h7FFF}}, 2'd0, 3, 0, 16'h7FFF);
      run_inf("sat_neg", {4{16'h8001}}, {4{16'h8001}}, 2'd0, 1, 0, 16'h8000);

      run_inf("backpressure", {4{16'h0001}}, {4{16'h0001}}, 2'd0, 0, 10, 16'h03FF);
      run_inf("back_to_back", {4{16'hFFFF}}, {4{16'h0000}}, 2'd0, 0, 0, 16'hFE00);

      load_w({4{16'h0200}}, 33'd0);
      load_w({4{16'h0100}}, 33'd0);
      load_w({4{16'h0300}}, 33'd0);
      run_inf("wrap", {4{16'h0100}}, {4{16'h0100}}, 2'd0, 0, 0, 16'h1000);

      load_w({4{16'h0100}}, 33'd0);
      load_w({4{16'h0100}}, 33'd0);
      load_b(16'h0040);
      act_mode = 2'd0;
      in_data = {4{16'h0080}};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_out_valid", 64'(out_valid), 64'(0));
      check("abort_in_ready", 64'(in_ready), 64'(1));
      repeat (12) tick();
      check("abort_no_result", 64'(out_valid), 64'(0));
      run_inf("after_abort", {4{16'h0080}}, {4{16'h0080}}, 2'd0, 0, 0, 16'h0440);

      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
